// File: rtl/touch_panel_scan_ctrl.sv
// touch_panel_scan_ctrl
// Autonomous XPT2046-style scan sequencer. It masters the SPI core's register
// port and runs one X/Y conversion frame per sample period while the pen is down.
// The resulting 12-bit coordinates are published with a one-cycle valid pulse.
// Every register-port access asserts select with one strobe for two cycles and
// is followed by one idle cycle. The bus outputs are registered from the
// next-state decode, so the bus lines up with the FSM phase.
module touch_panel_scan_ctrl #(
    parameter int unsigned SAMPLE_DIV = 150000,
    parameter logic [7:0]  CMD_X      = 8'hD0,
    parameter logic [7:0]  CMD_Y      = 8'h90,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        penirq_n,
    output logic        spi_select,
    output logic        spi_read_n,
    output logic        spi_write_n,
    output logic [2:0]  spi_addr,
    output logic [15:0] spi_wdata,
    input  logic [15:0] spi_rdata,
    output logic [11:0] touch_x,
    output logic [11:0] touch_y,
    output logic        touch_valid,
    output logic        touch_down,
    output logic        busy,
    output logic        err
);

    localparam int unsigned      CNT_W    = $clog2(SAMPLE_DIV);
    localparam int unsigned      TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CLR    = 4'd1,
        S_SSON   = 4'd2,
        S_POLL_T = 4'd3,
        S_WR_TX  = 4'd4,
        S_POLL_R = 4'd5,
        S_RD_RX  = 4'd6,
        S_SSOFF  = 4'd7,
        S_PUB    = 4'd8
    } state_t;

    // Command byte sent for transfer n of the frame
    function automatic logic [7:0] tx_byte(input logic [2:0] n);
        logic [7:0] b;
        case (n)
            3'd0:    b = CMD_X;
            3'd3:    b = CMD_Y;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t           state_r, state_s;
    logic [1:0]       ph_r, ph_s;          // 0,1 = strobe asserted, 2 = idle cycle
    logic [2:0]       byte_r, byte_s;
    logic             abort_r, abort_s;
    logic             timeout_s;
    logic             acc_end_s;
    logic             poll_to_s;
    logic [TO_W-1:0]  poll_cnt_r;
    logic [CNT_W-1:0] sample_cnt_r;
    logic             tick_s;
    logic             frame_start_s;
    logic             pen_meta_r, pen_sync_r;
    logic [7:0]       status_r;
    logic [5:0][7:0]  rx_r;
    logic             rd_s, wr_s, bus_on_s;
    logic [2:0]       addr_s;
    logic [15:0]      wdata_s;
    logic             in_poll_s;
    logic             in_read_s;

    assign touch_down    = ~pen_sync_r;
    assign tick_s        = enable && (sample_cnt_r == CNT_LAST);
    assign frame_start_s = tick_s && touch_down && (state_r == S_IDLE);
    assign in_poll_s     = (state_r == S_POLL_T) || (state_r == S_POLL_R);
    assign in_read_s     = in_poll_s || (state_r == S_RD_RX);

    // Next state, access phase, byte index and the bus command for the next cycle
    always_comb begin
        state_s   = state_r;
        ph_s      = ph_r;
        byte_s    = byte_r;
        abort_s   = abort_r;
        timeout_s = 1'b0;
        acc_end_s = (ph_r == 2'd2);
        poll_to_s = (poll_cnt_r >= TO_LAST);
        case (state_r)
            S_IDLE: begin
                if (frame_start_s) begin
                    state_s = S_CLR;
                    ph_s    = 2'd0;
                    byte_s  = 3'd0;
                    abort_s = 1'b0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PUB: begin
                state_s = S_IDLE;
            end
            default: begin
                if (!acc_end_s) begin
                    ph_s = ph_r + 2'd1;
                end else begin
                    ph_s = 2'd0;
                    case (state_r)
                        S_CLR:  state_s = S_SSON;
                        S_SSON: state_s = S_POLL_T;
                        S_POLL_T: begin
                            if (status_r[6]) begin
                                state_s = S_WR_TX;
                            end else if (poll_to_s) begin
                                state_s   = S_SSOFF;
                                abort_s   = 1'b1;
                                timeout_s = 1'b1;
                            end else begin
                                state_s = S_POLL_T;
                            end
                        end
                        S_WR_TX: state_s = S_POLL_R;
                        S_POLL_R: begin
                            if (status_r[7]) begin
                                state_s = S_RD_RX;
                            end else if (poll_to_s) begin
                                state_s   = S_SSOFF;
                                abort_s   = 1'b1;
                                timeout_s = 1'b1;
                            end else begin
                                state_s = S_POLL_R;
                            end
                        end
                        S_RD_RX: begin
                            if (byte_r == 3'd5) begin
                                state_s = S_SSOFF;
                            end else begin
                                byte_s  = byte_r + 3'd1;
                                state_s = S_POLL_T;
                            end
                        end
                        S_SSOFF: begin
                            if (abort_r) begin
                                state_s = S_IDLE;
                            end else begin
                                state_s = S_PUB;
                            end
                        end
                        default: state_s = S_IDLE;
                    endcase
                end
            end
        endcase

        bus_on_s = (ph_s != 2'd2);
        rd_s     = 1'b0;
        wr_s     = 1'b0;
        addr_s   = 3'd0;
        wdata_s  = 16'h0000;
        case (state_s)
            S_CLR: begin
                wr_s   = 1'b1;
                addr_s = 3'd2;
            end
            S_SSON: begin
                wr_s    = 1'b1;
                addr_s  = 3'd3;
                wdata_s = 16'h0400;
            end
            S_POLL_T, S_POLL_R: begin
                rd_s   = 1'b1;
                addr_s = 3'd2;
            end
            S_WR_TX: begin
                wr_s    = 1'b1;
                addr_s  = 3'd1;
                wdata_s = {8'h00, tx_byte(byte_s)};
            end
            S_RD_RX: begin
                rd_s   = 1'b1;
                addr_s = 3'd0;
            end
            S_SSOFF: begin
                wr_s   = 1'b1;
                addr_s = 3'd3;
            end
            default: begin
                rd_s = 1'b0;
                wr_s = 1'b0;
            end
        endcase
    end

    // FSM state, phase and frame bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            ph_r    <= 2'd0;
            byte_r  <= 3'd0;
            abort_r <= 1'b0;
        end else begin
            state_r <= state_s;
            ph_r    <= ph_s;
            byte_r  <= byte_s;
            abort_r <= abort_s;
        end
    end

    // Registered bus drive; strobes follow the next-cycle command
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spi_select  <= 1'b0;
            spi_read_n  <= 1'b1;
            spi_write_n <= 1'b1;
            spi_addr    <= 3'd0;
            spi_wdata   <= 16'h0000;
        end else begin
            spi_select  <= (rd_s || wr_s) && bus_on_s;
            spi_read_n  <= ~(rd_s && bus_on_s);
            spi_write_n <= ~(wr_s && bus_on_s);
            spi_addr    <= addr_s;
            spi_wdata   <= wdata_s;
        end
    end

    // Read data capture on the second asserted cycle of a read access
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            status_r <= 8'h00;
            rx_r     <= '0;
        end else begin
            if (in_poll_s && (ph_r == 2'd1)) begin
                status_r <= spi_rdata[7:0];
            end
            if ((state_r == S_RD_RX) && (ph_r == 2'd1)) begin
                rx_r[byte_r] <= spi_rdata[7:0];
            end
        end
    end

    // Poll-cycle counter: zero outside the poll states, so it restarts on every entry
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            poll_cnt_r <= '0;
        end else if (in_poll_s) begin
            if (poll_cnt_r != TO_MAX) begin
                poll_cnt_r <= poll_cnt_r + TO_W'(1);
            end
        end else begin
            poll_cnt_r <= '0;
        end
    end

    // Free-running sample-period counter, parked at zero while scanning is disabled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sample_cnt_r <= '0;
        end else if (!enable || (sample_cnt_r == CNT_LAST)) begin
            sample_cnt_r <= '0;
        end else begin
            sample_cnt_r <= sample_cnt_r + CNT_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous pen-down pin (idles released)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pen_meta_r <= 1'b1;
            pen_sync_r <= 1'b1;
        end else begin
            pen_meta_r <= penirq_n;
            pen_sync_r <= pen_meta_r;
        end
    end

    // Coordinate publication, busy and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            touch_x     <= 12'h000;
            touch_y     <= 12'h000;
            touch_valid <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            busy <= (state_s != S_IDLE);
            if ((state_r == S_PUB) && touch_down) begin
                touch_x     <= {rx_r[1][6:0], rx_r[2][7:3]};
                touch_y     <= {rx_r[4][6:0], rx_r[5][7:3]};
                touch_valid <= 1'b1;
            end else begin
                touch_valid <= 1'b0;
            end
            if (!enable) begin
                err <= 1'b0;
            end else if (timeout_s) begin
                err <= 1'b1;
            end else begin
                err <= err;
            end
        end
    end

endmodule

// File: tb/tb_touch_panel_scan_ctrl.sv
// Bench for touch_panel_scan_ctrl: behavioural SPI register-port model,
// a table of conversion frames, and hand-written corner-case sequences.
module tb_touch_panel_scan_ctrl;

    localparam int SDIV = 200;
    localparam int TO   = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        penirq_n;
    logic        spi_select, spi_read_n, spi_write_n;
    logic [2:0]  spi_addr;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata;
    logic [11:0] touch_x, touch_y;
    logic        touch_valid, touch_down, busy, err;

    touch_panel_scan_ctrl #(
        .SAMPLE_DIV (SDIV),
        .CMD_X      (8'hD0),
        .CMD_Y      (8'h90),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .penirq_n    (penirq_n),
        .spi_select  (spi_select),
        .spi_read_n  (spi_read_n),
        .spi_write_n (spi_write_n),
        .spi_addr    (spi_addr),
        .spi_wdata   (spi_wdata),
        .spi_rdata   (spi_rdata),
        .touch_x     (touch_x),
        .touch_y     (touch_y),
        .touch_valid (touch_valid),
        .touch_down  (touch_down),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // SPI core model state
    logic [47:0] m_rx = 48'h0;     // byte 0 in [47:40]
    logic        m_no_rrdy = 1'b0;
    logic        m_rrdy = 1'b0;
    int          m_idx = 0;
    logic [7:0]  m_byte;

    // Monitor state
    int          sel_run = 0;
    int          proto_err = 0;
    int          acc_cnt = 0;
    int          valid_cnt = 0;
    int          tx_cnt = 0;
    logic        last_rd0 = 1'b0;
    logic [18:0] wr_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    assign m_byte = (m_idx < 6) ? m_rx[8*(5-m_idx) +: 8] : 8'h00;

    // Register-port read data: status has TRDY always set, rx carries junk upper byte
    always_comb begin
        spi_rdata = 16'hFFFF;
        if (spi_addr == 3'd2) begin
            spi_rdata = {8'h00, m_rrdy, 1'b1, 6'b000000};
        end else if (spi_addr == 3'd0) begin
            spi_rdata = {8'hA5, m_byte};
        end else begin
            spi_rdata = 16'hFFFF;
        end
    end

    // Bus monitor and SPI core behaviour, sampled away from the active edge
    always @(negedge clk) begin
        if (!reset_n) begin
            sel_run  <= 0;
            m_rrdy   <= 1'b0;
            m_idx    <= 0;
            last_rd0 <= 1'b0;
        end else begin
            if (touch_valid) valid_cnt <= valid_cnt + 1;
            if (spi_select) begin
                sel_run  <= sel_run + 1;
                last_rd0 <= (!spi_read_n) && (spi_addr == 3'd0);
                if ((spi_read_n == spi_write_n) || (sel_run >= 2)) proto_err <= proto_err + 1;
                if (sel_run == 0) begin
                    acc_cnt <= acc_cnt + 1;
                    if (!spi_write_n) begin
                        wr_q.push_back({spi_addr, spi_wdata});
                        if (spi_addr == 3'd2) begin
                            m_rrdy <= 1'b0;
                            m_idx  <= 0;
                        end
                        if (spi_addr == 3'd1) begin
                            tx_cnt <= tx_cnt + 1;
                            m_rrdy <= !m_no_rrdy;
                        end
                    end
                end
            end else begin
                if ((sel_run != 0) && (sel_run != 2)) proto_err <= proto_err + 1;
                sel_run <= 0;
                if ((sel_run != 0) && last_rd0) begin
                    m_rrdy <= 1'b0;
                    m_idx  <= m_idx + 1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (touch_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("valid_wait", 32'(got), 32'd1);
    endtask

    task automatic wait_tx(input int base, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_cnt - base >= n) break;
        end
        check("tx_wait", 32'(tx_cnt - base >= n), 32'd1);
    endtask

    typedef struct packed {
        logic [47:0] rx;
        logic [11:0] x;
        logic [11:0] y;
    } vec_t;

    vec_t vecs [4];

    task automatic run_frame(input vec_t v);
        logic [2:0]  exp_a [9];
        logic [15:0] exp_d [9];
        int vb, wb, mism;
        exp_a = '{3'd2, 3'd3, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd3};
        exp_d = '{16'h0000, 16'h0400, 16'h00D0, 16'h0000, 16'h0000,
                  16'h0090, 16'h0000, 16'h0000, 16'h0000};
        enable = 1'b0;
        wait_idle(400);
        m_rx      = v.rx;
        m_no_rrdy = 1'b0;
        penirq_n  = 1'b0;
        vb = valid_cnt;
        wb = wr_q.size();
        @(negedge clk);
        enable = 1'b1;
        wait_valid(3 * SDIV);
        check("touch_down", 32'(touch_down), 32'd1);
        enable = 1'b0;
        wait_idle(400);
        repeat (4) @(negedge clk);
        check("touch_x", 32'(touch_x), 32'(v.x));
        check("touch_y", 32'(touch_y), 32'(v.y));
        check("valid_pulses", 32'(valid_cnt - vb), 32'd1);
        check("write_count", 32'(wr_q.size() - wb), 32'd9);
        mism = 0;
        for (int k = 0; k < 9; k++) begin
            if (wb + k < wr_q.size()) begin
                if (wr_q[wb+k][18:16] !== exp_a[k]) mism++;
                if ((k != 0) && (wr_q[wb+k][15:0] !== exp_d[k])) mism++;
            end
        end
        check("write_log", 32'(mism), 32'd0);
    endtask

    initial begin
        int ab, vb, wb, tb0;
        vecs[0] = {48'h0055E0000918, 12'hABC, 12'h123};
        vecs[1] = {48'h00FFF8007FF8, 12'hFFF, 12'hFFF};
        vecs[2] = {48'hFF8007FF8007, 12'h000, 12'h000};
        vecs[3] = {48'h002AA8001550, 12'h555, 12'h2AA};

        // Reset state
        reset_n  = 1'b0;
        enable   = 1'b1;
        penirq_n = 1'b0;
        m_rx     = vecs[0].rx;
        repeat (5) @(negedge clk);
        check("rst_select",  32'(spi_select),  32'd0);
        check("rst_read_n",  32'(spi_read_n),  32'd1);
        check("rst_write_n", 32'(spi_write_n), 32'd1);
        check("rst_addr",    32'(spi_addr),    32'd0);
        check("rst_wdata",   32'(spi_wdata),   32'd0);
        check("rst_x",       32'(touch_x),     32'd0);
        check("rst_y",       32'(touch_y),     32'd0);
        check("rst_valid",   32'(touch_valid), 32'd0);
        check("rst_down",    32'(touch_down),  32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_err",     32'(err),         32'd0);
        reset_n = 1'b1;
        ab = acc_cnt;
        repeat (SDIV - 5) @(negedge clk);
        check("no_access_before_tick", 32'(acc_cnt - ab), 32'd0);

        // Table of conversion frames
        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i]);
        end

        // Pen up for three sample ticks: no traffic at all
        enable = 1'b0;
        wait_idle(400);
        penirq_n = 1'b1;
        repeat (3) @(negedge clk);
        ab = acc_cnt;
        vb = valid_cnt;
        enable = 1'b1;
        repeat (3 * SDIV + 10) @(negedge clk);
        check("penup_accesses", 32'(acc_cnt - ab), 32'd0);
        check("penup_valid", 32'(valid_cnt - vb), 32'd0);
        check("penup_down", 32'(touch_down), 32'd0);

        // Pen released during byte 4; enable also drops mid-frame
        enable = 1'b0;
        wait_idle(400);
        m_rx     = vecs[1].rx;
        penirq_n = 1'b0;
        vb  = valid_cnt;
        wb  = wr_q.size();
        tb0 = tx_cnt;
        @(negedge clk);
        enable = 1'b1;
        wait_tx(tb0, 5, 3 * SDIV);
        penirq_n = 1'b1;
        enable   = 1'b0;
        wait_idle(400);
        repeat (4) @(negedge clk);
        check("release_valid", 32'(valid_cnt - vb), 32'd0);
        check("release_keep_x", 32'(touch_x), 32'h555);
        check("release_keep_y", 32'(touch_y), 32'h2AA);
        check("release_writes", 32'(wr_q.size() - wb), 32'd9);
        check("release_ssoff", 32'(wr_q[wr_q.size()-1]), 32'({3'd3, 16'h0000}));

        // RRDY never set: timeout, SS released, no publication
        m_no_rrdy = 1'b1;
        penirq_n  = 1'b0;
        vb = valid_cnt;
        wb = wr_q.size();
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 3 * SDIV + 4 * TO; i++) begin
            @(negedge clk);
            if (err) break;
        end
        check("timeout_err", 32'(err), 32'd1);
        wait_idle(50);
        check("timeout_err_sticky", 32'(err), 32'd1);
        check("timeout_writes", 32'(wr_q.size() - wb), 32'd4);
        check("timeout_ssoff", 32'(wr_q[wr_q.size()-1]), 32'({3'd3, 16'h0000}));
        check("timeout_valid", 32'(valid_cnt - vb), 32'd0);
        check("timeout_keep_x", 32'(touch_x), 32'h555);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("err_cleared", 32'(err), 32'd0);
        m_no_rrdy = 1'b0;

        // Reset during byte 2, then a normal frame
        wait_idle(400);
        m_rx     = vecs[0].rx;
        penirq_n = 1'b0;
        tb0 = tx_cnt;
        @(negedge clk);
        enable = 1'b1;
        wait_tx(tb0, 3, 3 * SDIV);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_busy",    32'(busy),        32'd0);
        check("midrst_select",  32'(spi_select),  32'd0);
        check("midrst_read_n",  32'(spi_read_n),  32'd1);
        check("midrst_write_n", 32'(spi_write_n), 32'd1);
        check("midrst_x",       32'(touch_x),     32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_frame(vecs[0]);

        check("bus_protocol", 32'(proto_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
